// File: rtl/inst_fetch.sv
// Instruction fetch unit: single-outstanding-request fetcher with a one-entry
// instruction hold register, branch/jump redirect handling, and a sticky
// misaligned-target flag.
module inst_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic        redirect_jalr,
  input  logic [63:0] redir_pc,
  input  logic [63:0] rs1_val,
  input  logic [63:0] imm,
  output logic        misalign_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  // Raw redirect target before word alignment; jalr clears bit 0.
  function automatic logic [63:0] calc_target(
    input logic        f_jalr,
    input logic [63:0] f_redir_pc,
    input logic [63:0] f_rs1,
    input logic [63:0] f_imm
  );
    logic [63:0] sum;
    if (f_jalr) begin
      sum = f_rs1 + f_imm;
      sum[0] = 1'b0;
    end else begin
      sum = f_redir_pc + f_imm;
    end
    return sum;
  endfunction

  // Fetch addresses are always word aligned.
  function automatic logic [63:0] align_word(input logic [63:0] a);
    return {a[63:2], 2'b00};
  endfunction

  logic [1:0]  r_state;
  logic [63:0] r_pc;
  logic [63:0] r_pending_pc;
  logic [31:0] r_inst;
  logic [63:0] r_inst_pc;
  logic        r_misalign;
  logic        r_imem_req;
  logic        r_inst_valid;

  logic [1:0]  w_state_nxt;
  logic [63:0] w_pc_nxt;
  logic [63:0] w_pending_nxt;
  logic [31:0] w_inst_nxt;
  logic [63:0] w_inst_pc_nxt;
  logic        w_misalign_nxt;
  logic [63:0] w_target_raw;
  logic [63:0] w_target;

  assign w_target_raw = calc_target(redirect_jalr, redir_pc, rs1_val, imm);
  assign w_target     = align_word(w_target_raw);

  // Next-state and datapath decisions; redirect outranks both ready inputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pending_nxt  = r_pending_pc;
    w_inst_nxt     = r_inst;
    w_inst_pc_nxt  = r_inst_pc;
    w_misalign_nxt = r_misalign;
    case (r_state)
      IDLE: begin
        // Redirects are ignored here; always start at the reset vector.
        w_state_nxt = FETCH;
        w_pc_nxt    = align_word(RESET_PC);
      end
      FETCH: begin
        if (redirect) begin
          w_misalign_nxt = r_misalign | w_target_raw[1];
          if (imem_ready) begin
            // Response arrived with the redirect: drop it, refetch at target.
            w_pc_nxt = w_target;
          end else begin
            // Request still outstanding: keep address stable, wait it out.
            w_pending_nxt = w_target;
            w_state_nxt   = DRAIN;
          end
        end else if (imem_ready) begin
          w_inst_nxt    = imem_rdata;
          w_inst_pc_nxt = r_pc;
          w_state_nxt   = HOLD;
        end else begin
          w_state_nxt = FETCH;
        end
      end
      DRAIN: begin
        if (redirect) begin
          w_misalign_nxt = r_misalign | w_target_raw[1];
          if (imem_ready) begin
            w_pc_nxt    = w_target;
            w_state_nxt = FETCH;
          end else begin
            // Latest redirect wins.
            w_pending_nxt = w_target;
          end
        end else if (imem_ready) begin
          w_pc_nxt    = r_pending_pc;
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      HOLD: begin
        if (redirect) begin
          w_misalign_nxt = r_misalign | w_target_raw[1];
          w_pc_nxt       = w_target;
          w_state_nxt    = FETCH;
        end else if (inst_ready) begin
          w_pc_nxt    = r_inst_pc + 64'd4;
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_pc_nxt    = align_word(RESET_PC);
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pc         <= align_word(RESET_PC);
      r_pending_pc <= 64'd0;
      r_inst       <= 32'd0;
      r_inst_pc    <= 64'd0;
      r_misalign   <= 1'b0;
      r_imem_req   <= 1'b0;
      r_inst_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pending_pc <= w_pending_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
      r_misalign   <= w_misalign_nxt;
      r_imem_req   <= (w_state_nxt == FETCH) || (w_state_nxt == DRAIN);
      r_inst_valid <= (w_state_nxt == HOLD);
    end
  end

  assign imem_req     = r_imem_req;
  assign imem_addr    = r_pc;
  assign inst_valid   = r_inst_valid;
  assign inst         = r_inst;
  assign inst_pc      = r_inst_pc;
  assign misalign_err = r_misalign;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, meaning the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction-memory request, held until imem_ready.
REQ-005 imem_addr  output  64  fetch address, bits [1:0] always 2'b00.
REQ-006 imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-007 imem_ready  input  1  response for the outstanding request; may assert in the same cycle as imem_req.
REQ-008 inst_valid  output  1  instruction available to decode/ImmGen stage.
REQ-009 inst  output  32  fetched instruction.
REQ-010 inst_pc  output  64  address of inst.
REQ-011 inst_ready  input  1  downstream accepts inst when inst_valid=1.
REQ-012 redirect  input  1  control-flow change from the execute stage, single-cycle pulse.
REQ-013 redirect_jalr  input  1  target = rs1_val + imm (1) or redir_pc + imm (0).
REQ-014 redir_pc  input  64  PC of the redirecting branch/jal.
REQ-015 rs1_val  input  64  jalr base register value.
REQ-016 imm  input  64  sign-extended immediate from ImmGen.
REQ-017 misalign_err  output  1  sticky flag: a redirect target had bit 1 set.

Function
REQ-018 The block SHALL implement states IDLE, FETCH, DRAIN, HOLD; imem_req=1 only in FETCH and DRAIN; inst_valid=1 only in HOLD.
REQ-019 IDLE SHALL last exactly one cycle after rst_n deasserts, then go to FETCH with pc=RESET_PC.
REQ-020 In FETCH, imem_addr SHALL equal pc and SHALL stay stable while imem_ready=0.
REQ-021 FETCH with imem_ready=1 and no redirect SHALL capture imem_rdata into inst, pc into inst_pc, and go to HOLD (fetch latency 1 cycle minimum).
REQ-022 HOLD with inst_ready=1 and no redirect SHALL set pc=inst_pc+4 (64-bit, wraps modulo 2^64) and go to FETCH.
REQ-023 HOLD with inst_ready=0 SHALL keep inst, inst_pc, inst_valid unchanged.
REQ-024 Target SHALL be (redirect_jalr ? rs1_val+imm with bit0 cleared : redir_pc+imm), computed modulo 2^64.
REQ-025 Redirect SHALL take priority over inst_ready and imem_ready in the same cycle.
REQ-026 Redirect in HOLD SHALL drop the held instruction (inst_valid=0 next cycle), set pc=target, go to FETCH.
REQ-027 Redirect in FETCH with imem_ready=1 SHALL discard imem_rdata, set pc=target, stay in FETCH.
REQ-028 Redirect in FETCH with imem_ready=0 SHALL latch target into pending_pc, keep imem_addr unchanged, go to DRAIN.
REQ-029 DRAIN with imem_ready=1 SHALL discard the response, set pc=pending_pc, go to FETCH; a further redirect in DRAIN SHALL overwrite pending_pc (the latest redirect wins).
REQ-030 Target bit 1 = 1 SHALL set misalign_err, and the fetch SHALL proceed with bits [1:0] forced to 00.
REQ-031 Redirect in IDLE SHALL be ignored.

Reset
REQ-032 rst_n=0 SHALL force, immediately: state=IDLE, pc=RESET_PC, imem_req=0, inst_valid=0, inst=32'h0, inst_pc=0, misalign_err=0, pending_pc=0.
REQ-033 Reset asserted mid-transaction SHALL abandon any outstanding request; a late imem_ready after reset SHALL be ignored unless in FETCH/DRAIN.

Verification
REQ-034 Reset release, imem_ready tied 1, inst_ready tied 1 -> imem_addr sequence 0,4,8 on alternate cycles, with inst_pc matching each address.
REQ-035 imem_ready held 0 for 3 cycles in FETCH at pc=0x10 -> imem_addr stays 0x10 and inst_valid stays 0; ready=1 with rdata=0x00500093 -> next cycle inst=0x00500093, inst_pc=0x10.
REQ-036 HOLD, inst_ready=0 for 4 cycles -> inst stable, imem_req=0; redirect redir_pc=0x100, imm=-8 -> next cycle inst_valid=0, imem_addr=0xF8.
REQ-037 Redirect jalr rs1_val=0x2001, imm=0x10 in FETCH with imem_ready=0 -> DRAIN; ready=1 with data -> data discarded, next imem_addr=0x2010.
REQ-038 Redirect target 0x106 -> misalign_err=1 and imem_addr=0x104; misalign_err holds until rst_n pulse.
